// File: rtl/ball_motion.sv
// Pong ball engine: steps the ball on a divided move tick, bounces it off the
// top/bottom walls and both paddles, detects misses, keeps score and drives
// guiwei so the paddles return home after each point.
//
// state | meaning
// IDLE  | ball parked at centre, waiting for start
// SERVE | ball parked at centre for SERVE_TICKS move ticks
// MOVE  | ball in play, one STEP per axis per move tick
// SCORE | ball frozen after a miss, guiwei high for SCORE_TICKS move ticks
// OVER  | a player reached WIN_SCORE, waiting for start
module ball_motion #(
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int SLDE_W      = 10,
  parameter int BALL_W      = 10,
  parameter int PAD_W       = 10,
  parameter int PAD_L       = 80,
  parameter int LPAD_X      = 55,
  parameter int RPAD_X      = 575,
  parameter int STEP        = 2,
  parameter int DIV_FAST    = 80000,
  parameter int DIV_SLOW    = 190000,
  parameter int SERVE_TICKS = 60,
  parameter int SCORE_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       s,
  input  logic       start,
  input  logic [9:0] lpad_y,
  input  logic [9:0] rpad_y,
  output logic [9:0] ballbody_x,
  output logic [9:0] ballbody_y,
  output logic       guiwei,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int DIV_MAX  = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int DIV_W    = $clog2(DIV_MAX);
  localparam int HOLD_MAX = (SERVE_TICKS > SCORE_TICKS) ? SERVE_TICKS : SCORE_TICKS;
  localparam int TMR_W    = $clog2(HOLD_MAX + 1);

  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);
  localparam logic [TMR_W-1:0] SERVE_LD  = TMR_W'(SERVE_TICKS - 1);
  localparam logic [TMR_W-1:0] SCORE_LD  = TMR_W'(SCORE_TICKS - 1);

  localparam logic [9:0] X0 = 10'(H_DISP / 2 - BALL_W / 2);
  localparam logic [9:0] Y0 = 10'(V_DISP / 2 - BALL_W / 2);
  localparam logic [3:0] WIN_S = 4'(WIN_SCORE);

  // All geometry compares run at 11 bits so paddle/ball sums never wrap.
  localparam logic [10:0] C_STEP   = 11'(STEP);
  localparam logic [10:0] C_BALL   = 11'(BALL_W);
  localparam logic [10:0] C_PADL   = 11'(PAD_L);
  localparam logic [10:0] C_TOP    = 11'(SLDE_W);
  localparam logic [10:0] C_BOT    = 11'(V_DISP - SLDE_W - BALL_W);
  localparam logic [10:0] C_LFACE  = 11'(LPAD_X + PAD_W);
  localparam logic [10:0] C_RFACE  = 11'(RPAD_X);
  localparam logic [10:0] C_RSTOP  = 11'(RPAD_X - BALL_W);
  localparam logic [10:0] C_LMISS  = 11'(SLDE_W + STEP);
  localparam logic [10:0] C_RMISS  = 11'(H_DISP - SLDE_W - STEP);

  typedef enum logic [2:0] {IDLE, SERVE, MOVE, SCORE, OVER} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_last;
  logic               tick;
  logic [TMR_W-1:0]   hold_cnt;
  logic               dx;         // 1 = moving right
  logic               dy;         // 1 = moving down

  logic [10:0] x_w, y_w, lpy_w, rpy_w;
  logic [9:0]  x_nxt, y_nxt;
  logic        dx_nxt, dy_nxt;
  logic        ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

  assign div_last = s ? FAST_LAST : SLOW_LAST;
  // The >= compare makes a switch to the shorter period fire at once instead of running away.
  assign tick     = (div_cnt >= div_last);

  // Move-tick divider: free-running, wraps on the tick.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) div_cnt <= '0;
    else            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end

  assign x_w   = {1'b0, ballbody_x};
  assign y_w   = {1'b0, ballbody_y};
  assign lpy_w = {1'b0, lpad_y};
  assign rpy_w = {1'b0, rpad_y};

  assign ovl_l  = (y_w + C_BALL > lpy_w) && (y_w < lpy_w + C_PADL);
  assign ovl_r  = (y_w + C_BALL > rpy_w) && (y_w < rpy_w + C_PADL);
  assign hit_l  = !dx && (x_w >= C_LFACE) && (x_w - C_STEP <= C_LFACE) && ovl_l;
  assign hit_r  = dx && (x_w + C_BALL <= C_RFACE) && (x_w + C_BALL + C_STEP >= C_RFACE) && ovl_r;
  assign miss_l = !dx && (x_w <= C_LMISS) && !hit_l;
  assign miss_r = dx && (x_w + C_BALL >= C_RMISS) && !hit_r;

  // Next ball position and direction for one move tick; wall and paddle rules are independent.
  always_comb begin
    y_nxt  = ballbody_y;
    dy_nxt = dy;
    if (!dy) begin
      if (y_w <= C_TOP + C_STEP) begin
        y_nxt  = 10'(C_TOP);
        dy_nxt = 1'b1;
      end else begin
        y_nxt  = 10'(y_w - C_STEP);
      end
    end else begin
      if (y_w >= C_BOT - C_STEP) begin
        y_nxt  = 10'(C_BOT);
        dy_nxt = 1'b0;
      end else begin
        y_nxt  = 10'(y_w + C_STEP);
      end
    end

    dx_nxt = dx;
    if (hit_l) begin
      x_nxt  = 10'(C_LFACE);
      dx_nxt = 1'b1;
    end else if (hit_r) begin
      x_nxt  = 10'(C_RSTOP);
      dx_nxt = 1'b0;
    end else if (dx) begin
      x_nxt  = 10'(x_w + C_STEP);
    end else begin
      x_nxt  = 10'(x_w - C_STEP);
    end
  end

  // Game FSM with registered ball position, scores and status flags.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      ballbody_x <= X0;
      ballbody_y <= Y0;
      dx         <= 1'b1;
      dy         <= 1'b1;
      hold_cnt   <= '0;
      guiwei     <= 1'b0;
      score_l    <= '0;
      score_r    <= '0;
      game_over  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ballbody_x <= X0;
          ballbody_y <= Y0;
          if (start) begin
            state    <= SERVE;
            hold_cnt <= SERVE_LD;
          end
        end
        SERVE: begin
          ballbody_x <= X0;
          ballbody_y <= Y0;
          if (tick) begin
            if (hold_cnt == '0) state <= MOVE;
            else                hold_cnt <= hold_cnt - TMR_W'(1);
          end
        end
        MOVE: begin
          if (tick) begin
            if (miss_l) begin
              score_r  <= (score_r == WIN_S) ? score_r : score_r + 4'd1;
              dx       <= 1'b0;
              guiwei   <= 1'b1;
              hold_cnt <= SCORE_LD;
              state    <= SCORE;
            end else if (miss_r) begin
              score_l  <= (score_l == WIN_S) ? score_l : score_l + 4'd1;
              dx       <= 1'b1;
              guiwei   <= 1'b1;
              hold_cnt <= SCORE_LD;
              state    <= SCORE;
            end else begin
              ballbody_x <= x_nxt;
              ballbody_y <= y_nxt;
              dx         <= dx_nxt;
              dy         <= dy_nxt;
            end
          end
        end
        SCORE: begin
          if (tick) begin
            if (hold_cnt == '0) begin
              guiwei     <= 1'b0;
              ballbody_x <= X0;
              ballbody_y <= Y0;
              if (score_l == WIN_S || score_r == WIN_S) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state    <= SERVE;
                hold_cnt <= SERVE_LD;
              end
            end else begin
              hold_cnt <= hold_cnt - TMR_W'(1);
            end
          end
        end
        OVER: begin
          ballbody_x <= X0;
          ballbody_y <= Y0;
          if (start) begin
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
            hold_cnt  <= SERVE_LD;
            state     <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
